// File: rtl/ft600_dev_responder.sv
// FT600 245-sync FIFO device-side responder: RX FIFO feeds master reads, master writes fill TX FIFO.
// Flags are registered from next-state counts; host push shows on rxf_n one cycle later, host pops are FWFT.
module ft600_dev_responder #(
   parameter int DATA_WIDTH = 16,
   parameter int BE_WIDTH   = 2,
   parameter int RX_DEPTH   = 16,
   parameter int TX_DEPTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  rxf_n,
   output logic                  txe_n,
   inout  wire [DATA_WIDTH-1:0]  data,
   inout  wire [BE_WIDTH-1:0]    be,
   input  logic                  rd_n,
   input  logic                  wr_n,
   input  logic                  oe_n,
   input  logic [DATA_WIDTH-1:0] dn_data,
   input  logic [BE_WIDTH-1:0]   dn_be,
   input  logic                  dn_valid,
   output logic                  dn_ready,
   output logic [DATA_WIDTH-1:0] up_data,
   output logic [BE_WIDTH-1:0]   up_be,
   output logic                  up_valid,
   input  logic                  up_ready,
   output logic                  proto_err
);

   localparam int WW  = DATA_WIDTH + BE_WIDTH;
   localparam int RAW = $clog2(RX_DEPTH);
   localparam int RCW = RAW + 1;
   localparam int TAW = $clog2(TX_DEPTH);
   localparam int TCW = TAW + 1;

   typedef enum logic [1:0] {IDLE, RD_TURN, RD, WR} state_t;
   state_t state;

   logic [WW-1:0]  rx_mem [RX_DEPTH];
   logic [RAW-1:0] rx_wptr, rx_rptr;
   logic [RCW-1:0] rx_cnt, rx_cnt_next;
   logic [WW-1:0]  rx_head;
   logic           rx_push, rx_pop;

   logic [WW-1:0]  tx_mem [TX_DEPTH];
   logic [TAW-1:0] tx_wptr, tx_rptr;
   logic [TCW-1:0] tx_cnt, tx_cnt_next;
   logic [WW-1:0]  tx_head;
   logic           tx_push, tx_pop;

   // Pop/push qualify on the registered flags, so neither FIFO can over- or underflow.
   assign rx_push     = dn_valid & dn_ready;
   assign rx_pop      = ~rd_n & ~oe_n & ~rxf_n;
   assign rx_cnt_next = rx_cnt + RCW'(rx_push) - RCW'(rx_pop);
   assign tx_push     = ~wr_n & oe_n & ~txe_n;
   assign tx_pop      = up_valid & up_ready;
   assign tx_cnt_next = tx_cnt + TCW'(tx_push) - TCW'(tx_pop);

   assign rx_head = rx_mem[rx_rptr];
   assign tx_head = tx_mem[tx_rptr];
   assign data    = oe_n ? {DATA_WIDTH{1'bz}} : rx_head[DATA_WIDTH-1:0];
   assign be      = oe_n ? {BE_WIDTH{1'bz}}   : rx_head[WW-1:DATA_WIDTH];
   assign up_data = tx_head[DATA_WIDTH-1:0];
   assign up_be   = tx_head[WW-1:DATA_WIDTH];

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wptr] <= {dn_be, dn_data};
      if (tx_push) tx_mem[tx_wptr] <= {be, data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_wptr  <= '0;
         rx_rptr  <= '0;
         rx_cnt   <= '0;
         tx_wptr  <= '0;
         tx_rptr  <= '0;
         tx_cnt   <= '0;
         rxf_n    <= 1'b1;
         txe_n    <= 1'b1;
         dn_ready <= 1'b0;
         up_valid <= 1'b0;
      end else begin
         if (rx_push) rx_wptr <= rx_wptr + RAW'(1);
         if (rx_pop)  rx_rptr <= rx_rptr + RAW'(1);
         if (tx_push) tx_wptr <= tx_wptr + TAW'(1);
         if (tx_pop)  tx_rptr <= tx_rptr + TAW'(1);
         rx_cnt   <= rx_cnt_next;
         tx_cnt   <= tx_cnt_next;
         rxf_n    <= (rx_cnt_next == '0);
         txe_n    <= (tx_cnt_next == TCW'(TX_DEPTH));
         dn_ready <= (rx_cnt_next != RCW'(RX_DEPTH));
         up_valid <= (tx_cnt_next != '0);
      end
   end

   // Bus-phase tracker; only used to flag master protocol violations.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         proto_err <= 1'b0;
      end else begin
         if ((!wr_n && !oe_n) || (state == IDLE && !rd_n) || (state == WR && !oe_n))
            proto_err <= 1'b1;
         case (state)
            IDLE:    if (!oe_n && rd_n) state <= RD_TURN;
                     else if (!wr_n)    state <= WR;
            RD_TURN: if (oe_n)          state <= IDLE;
                     else if (!rd_n)    state <= RD;
            RD:      if (oe_n)          state <= IDLE;
            WR:      if (wr_n)          state <= IDLE;
            default:                    state <= IDLE;
         endcase
      end
   end

endmodule
